// File: rtl/tpu_pkg.sv
// Shared definitions for the systolic-array edge feeders.
//   EMPTY_DATA     : word driven on any lane whose valid bit is low
//   feeder_state_e : transfer FSM states of the FIFO skew feeder
package tpu_pkg;

  // Wide enough for any lane width in use; users slice [WIDTH-1:0].
  localparam logic [63:0] EMPTY_DATA = 64'h0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } feeder_state_e;

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth delay line carrying one lane's data word and valid bit.
// DEPTH=0 is a pure pass-through. Reset clears every stage to EMPTY_DATA
// with valid low.
//   clk, rstn        : clock, synchronous active-low reset
//   data_i, valid_i  : lane word entering the line
//   data_o, valid_o  : the same word DEPTH cycles later
module skew_delay_line
  import tpu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o
);

  localparam logic [WIDTH-1:0] EMPTY_WORD = EMPTY_DATA[WIDTH-1:0];

  if (DEPTH == 0) begin : g_pass
    assign data_o  = data_i;
    assign valid_o = valid_i;

    // Lane 0 has no registers; keep the clock/reset pins formally consumed.
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, rstn};
  end else begin : g_line
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;

    always_ff @(posedge clk) begin
      if (!rstn) begin
        for (int k = 0; k < DEPTH; k++) begin
          data_q[k] <= EMPTY_WORD;
        end
        valid_q <= '0;
      end else begin
        data_q[0]  <= data_i;
        valid_q[0] <= valid_i;
        for (int k = 1; k < DEPTH; k++) begin
          data_q[k]  <= data_q[k-1];
          valid_q[k] <= valid_q[k-1];
        end
      end
    end

    assign data_o  = data_q[DEPTH-1];
    assign valid_o = valid_q[DEPTH-1];
  end

endmodule

// File: rtl/fifo_skew_feeder.sv
// Feeds one operand edge of the systolic array from CHANNELS parallel FWFT
// FIFOs. All FIFOs are popped together for len vectors; lane i is then
// delayed by i cycles to form the diagonal wavefront. Cycles where any FIFO
// is empty become bubbles (valid=0, EMPTY_DATA) on every lane.
//   clk, rstn       : clock, synchronous active-low reset
//   start, len      : transfer request and vector count, sampled in IDLE
//   empty           : per-FIFO empty flags
//   from_fifo       : per-FIFO head words, lane i at [i*WIDTH +: WIDTH]
//   r_en            : per-FIFO pop strobes (all or none)
//   to_array        : skewed lane words, lane i at [i*WIDTH +: WIDTH]
//   to_array_valid  : per-lane valid
//   busy            : high whenever not IDLE
//   done            : one-cycle completion pulse
module fifo_skew_feeder
  import tpu_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int CHANNELS  = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      start,
  input  logic [CNT_WIDTH-1:0]      len,
  input  logic [CHANNELS-1:0]       empty,
  input  logic [CHANNELS*WIDTH-1:0] from_fifo,
  output logic [CHANNELS-1:0]       r_en,
  output logic [CHANNELS*WIDTH-1:0] to_array,
  output logic [CHANNELS-1:0]       to_array_valid,
  output logic                      busy,
  output logic                      done
);

  // Drain counter runs 0..CHANNELS-2.
  localparam int DRAIN_W = (CHANNELS > 2) ? $clog2(CHANNELS - 1) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'((CHANNELS > 1) ? CHANNELS - 2 : 0);
  localparam logic [WIDTH-1:0] EMPTY_WORD = EMPTY_DATA[WIDTH-1:0];

  feeder_state_e             state_q, state_d;
  logic [CNT_WIDTH-1:0]      len_q, len_d;
  logic [CNT_WIDTH-1:0]      issue_q, issue_d;
  logic [DRAIN_W-1:0]        drain_q, drain_d;
  logic [CHANNELS*WIDTH-1:0] s0_data_q;
  logic                      s0_valid_q;
  logic                      fire;
  logic                      last_issue;

  // Pop only when every FIFO has a word; gating with rstn keeps the
  // strobes quiet during a reset cycle regardless of the current state.
  assign fire       = rstn && (state_q == FEED) && (&(~empty));
  assign last_issue = (issue_q == len_q - CNT_WIDTH'(1));
  assign r_en       = {CHANNELS{fire}};
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      len_q   <= '0;
      issue_q <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      issue_q <= issue_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    issue_d = issue_q;
    drain_d = drain_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len == '0) begin
            state_d = DONE;
          end else begin
            state_d = FEED;
            len_d   = len;
            issue_d = '0;
          end
        end
      end
      FEED: begin
        if (fire) begin
          issue_d = issue_q + CNT_WIDTH'(1);
          if (last_issue) begin
            drain_d = '0;
            // A single lane has no skew to flush.
            if (CHANNELS == 1) state_d = DONE;
            else               state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) state_d = DONE;
        else                       drain_d = drain_q + DRAIN_W'(1);
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Stage 0: captures the head words on a pop, otherwise a bubble.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s0_data_q  <= {CHANNELS{EMPTY_WORD}};
      s0_valid_q <= 1'b0;
    end else if (fire) begin
      s0_data_q  <= from_fifo;
      s0_valid_q <= 1'b1;
    end else begin
      s0_data_q  <= {CHANNELS{EMPTY_WORD}};
      s0_valid_q <= 1'b0;
    end
  end

  genvar gi;
  for (gi = 0; gi < CHANNELS; gi++) begin : g_lane
    skew_delay_line #(
      .WIDTH (WIDTH),
      .DEPTH (gi)
    ) u_skew (
      .clk     (clk),
      .rstn    (rstn),
      .data_i  (s0_data_q[gi*WIDTH +: WIDTH]),
      .valid_i (s0_valid_q),
      .data_o  (to_array[gi*WIDTH +: WIDTH]),
      .valid_o (to_array_valid[gi])
    );
  end

endmodule

// File: tb/tb_fifo_skew_feeder.sv
// Scoreboard bench for fifo_skew_feeder. FIFOs are modelled as queues; the
// reference decides each cycle whether a pop should happen, and every pop
// pushes one expected (word, cycle) entry per lane. A negedge monitor
// compares pop strobes, busy/done and every lane against the model.
module tb_fifo_skew_feeder;

  localparam int W   = 16;
  localparam int CH  = 4;
  localparam int CW  = 16;
  localparam int BIG = 32'h3fff_ffff;
  localparam logic [W-1:0] EMPTY_W = '0;

  typedef struct {
    logic [W-1:0] d;
    int           c;
  } exp_t;

  logic              clk = 1'b0;
  logic              rstn;
  logic              start;
  logic [CW-1:0]     len;
  logic [CH-1:0]     empty;
  logic [CH*W-1:0]   from_fifo;
  logic [CH-1:0]     r_en;
  logic [CH*W-1:0]   to_array;
  logic [CH-1:0]     to_array_valid;
  logic              busy;
  logic              done;

  fifo_skew_feeder #(
    .WIDTH     (W),
    .CHANNELS  (CH),
    .CNT_WIDTH (CW)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .start          (start),
    .len            (len),
    .empty          (empty),
    .from_fifo      (from_fifo),
    .r_en           (r_en),
    .to_array       (to_array),
    .to_array_valid (to_array_valid),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;
  bit mon_en = 0;

  // Reference model state
  bit   xfer_on    = 0;
  bit   feeding    = 0;
  int   busy_start = 0;
  int   exp_done   = 0;
  int   len_cur    = 0;
  int   pops_done  = 0;
  bit   fire_seen  = 0;
  int   stall_left = 0;
  bit   stall_arm  = 0;
  int   stall_pct  = 0;
  bit   auto_fill  = 1;
  int   pop_total [CH];

  logic [W-1:0] fq     [CH][$];
  exp_t         lane_q [CH][$];

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s cyc=%0d: got %0h, expected %0h", name, cyc, act, req);
  endtask

  function automatic bit model_busy(input int c);
    return xfer_on && (c >= busy_start) && (c <= exp_done);
  endfunction

  // Present FIFO heads / empties for the current cycle.
  task automatic drive_fifo();
    for (int i = 0; i < CH; i++) begin
      bit e;
      if (auto_fill)
        while (fq[i].size() < 3) fq[i].push_back(W'($urandom));
      e = (fq[i].size() == 0) || ($urandom_range(99) < 32'(stall_pct)) ||
          (i == 2 && stall_left > 0);
      empty[i] = e;
      from_fifo[i*W +: W] = e ? W'($urandom) : fq[i][0];
    end
    if (stall_left > 0) stall_left--;
  endtask

  // Apply the effect of the clock edge that ends cycle cyc.
  task automatic model_edge();
    if (!rstn) begin
      for (int i = 0; i < CH; i++) lane_q[i].delete();
      xfer_on    = 0;
      feeding    = 0;
      stall_left = 0;
      stall_arm  = 0;
      return;
    end
    if (fire_seen) begin
      for (int i = 0; i < CH; i++) begin
        exp_t e;
        e.d = fq[i][0];
        e.c = cyc + 1 + i;
        lane_q[i].push_back(e);
        void'(fq[i].pop_front());
      end
      pops_done++;
      if (stall_arm && pops_done == 2) begin
        stall_left = 2;
        stall_arm  = 0;
      end
      if (pops_done == len_cur) begin
        feeding  = 0;
        exp_done = cyc + CH;
      end
    end
    if (start && !model_busy(cyc)) begin
      xfer_on    = 1;
      busy_start = cyc + 1;
      if (len == '0) begin
        exp_done = cyc + 1;
      end else begin
        feeding   = 1;
        len_cur   = int'(len);
        pops_done = 0;
        exp_done  = BIG;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    drive_fifo();
  endtask

  task automatic monitor_cycle();
    bit            ef;
    logic [CH-1:0] exp_r;
    ef    = rstn && feeding && (pops_done < len_cur) && (empty == '0);
    exp_r = ef ? '1 : '0;
    chk(r_en === exp_r, "r_en", r_en, exp_r);
    fire_seen = ef;
    for (int i = 0; i < CH; i++) if (r_en[i] === 1'b1) pop_total[i]++;
    chk(busy === model_busy(cyc), "busy", busy, model_busy(cyc));
    chk(done === (xfer_on && cyc == exp_done), "done", done, (xfer_on && cyc == exp_done));
    for (int i = 0; i < CH; i++) begin
      logic [W-1:0] act;
      bit           has_exp;
      act     = to_array[i*W +: W];
      has_exp = (lane_q[i].size() > 0) && (lane_q[i][0].c == cyc);
      chk(to_array_valid[i] === has_exp, $sformatf("lane%0d_valid", i), to_array_valid[i], has_exp);
      if (has_exp) begin
        chk(act === lane_q[i][0].d, $sformatf("lane%0d_data", i), act, lane_q[i][0].d);
        void'(lane_q[i].pop_front());
      end else begin
        chk(act === EMPTY_W, $sformatf("lane%0d_bubble", i), act, EMPTY_W);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < CH; i++) pop_total[i] = 0;
    forever begin
      @(negedge clk);
      if (mon_en) monitor_cycle();
      else fire_seen = 0;
    end
  end

  task automatic start_xfer(input int l);
    start = 1'b1;
    len   = CW'(l);
    tick();
    start = 1'b0;
    len   = CW'($urandom);
  endtask

  // Wait for the model to finish, optionally pulsing a bogus start at
  // cycle offset ign_at (relative to the first FEED cycle).
  task automatic wait_idle(input int budget, input int ign_at);
    int n = 0;
    while (model_busy(cyc) && n < budget) begin
      start = (n == ign_at);
      if (n == ign_at) len = CW'(9);
      tick();
      n++;
    end
    start = 1'b0;
    chk(!model_busy(cyc), "xfer_timeout", n, budget);
    if (model_busy(cyc)) begin
      xfer_on = 0;
      feeding = 0;
    end
  endtask

  task automatic run_xfer(input int l, input int ign_at, input string name);
    int base [CH];
    int s;
    for (int i = 0; i < CH; i++) base[i] = pop_total[i];
    s = cyc;
    start_xfer(l);
    wait_idle(1000, ign_at);
    for (int i = 0; i < CH; i++)
      chk(pop_total[i] - base[i] == l, $sformatf("%s_pops_ch%0d", name, i), pop_total[i] - base[i], l);
    $display("xfer %s: start cyc=%0d len=%0d finished cyc=%0d", name, s, l, cyc);
  endtask

  initial begin
    // Reset held for 3 cycles with start asserted and FIFOs full.
    rstn      = 1'b0;
    start     = 1'b1;
    len       = CW'(5);
    empty     = '0;
    from_fifo = '0;
    drive_fifo();
    tick();
    mon_en = 1;
    tick();
    tick();
    rstn  = 1'b1;
    start = 1'b0;
    tick();
    tick();

    // Basic feed with recognisable lane words.
    auto_fill = 0;
    for (int i = 0; i < CH; i++) begin
      fq[i].delete();
      for (int n = 0; n < 6; n++) fq[i].push_back(W'((i << 8) + n));
    end
    drive_fifo();
    run_xfer(3, -1, "basic");
    for (int i = 0; i < CH; i++) fq[i].delete();
    auto_fill = 1;
    tick();

    // Two-cycle stall on channel 2 after the second pop.
    stall_arm = 1;
    run_xfer(4, -1, "stall");
    tick();

    // Zero-length transfer.
    run_xfer(0, -1, "len0");
    tick();

    // Start while busy is ignored; next start accepted in first IDLE cycle.
    run_xfer(5, 1, "protocol");
    run_xfer(2, -1, "b2b");

    // Reset in the middle of DRAIN.
    begin
      int base [CH];
      int n = 0;
      for (int i = 0; i < CH; i++) base[i] = pop_total[i];
      start_xfer(3);
      while (feeding && n < 100) begin tick(); n++; end
      tick();
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      for (int i = 0; i < CH; i++)
        chk(pop_total[i] - base[i] == 3, $sformatf("rst_pops_ch%0d", i), pop_total[i] - base[i], 3);
      $display("xfer reset_in_drain: reset at cyc=%0d", cyc - 1);
      for (int k = 0; k < 4; k++) tick();
    end
    run_xfer(6, -1, "after_reset");

    // Randomised transfers with random stalls and idle gaps.
    for (int k = 0; k < 24; k++) begin
      int l;
      int gap;
      l         = ($urandom_range(9) == 0) ? 0 : int'($urandom_range(12, 1));
      stall_pct = int'($urandom_range(30));
      gap       = int'($urandom_range(2));
      for (int g = 0; g < gap; g++) tick();
      run_xfer(l, ($urandom_range(3) == 0) ? int'($urandom_range(4)) : -1, $sformatf("rand%0d", k));
    end
    stall_pct = 0;
    for (int k = 0; k < 6; k++) tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passes, checks);
    $fatal(1, "watchdog");
  end

endmodule
